// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every handshake and memory signal around the
// unified-memory arbiter.
//   fetch side : if_req, if_addr            -> arbiter
//                if_gnt, if_rvalid, if_rdata <- arbiter
//   data side  : d_req, d_we, d_addr, d_wdata -> arbiter
//                d_gnt, d_rvalid, d_rdata     <- arbiter
//   memory side: mem_en, mem_we, mem_addr, mem_wdata <- arbiter
//                mem_rdata                           -> arbiter
//   status     : busy <- arbiter
// Modport "master" is the arbiter's view; "slave" is the surroundings' view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port memory between instruction fetch and
// load/store. One transaction at a time: IDLE picks a winner, ISSUE strobes
// the memory for one cycle, WAIT counts down the fixed read latency and
// returns the word with a one-cycle rvalid pulse.
// Data beats fetch, except that after STARVE_MAX consecutive fetch losses
// the next contested decision goes to fetch.
// Ports:
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : mem_arbiter_if.master (requesters, memory, busy)
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.master bus
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD    = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE     = LAT_W'(1);
  localparam logic [STV_W-1:0] STARVE_FULL = STV_W'(STARVE_MAX);
  localparam logic [STV_W-1:0] STARVE_ONE  = STV_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e            state_q;
  logic [LAT_W-1:0]  lat_q;
  logic [STV_W-1:0]  starve_q;
  logic              sel_data_q;  // winner of the transaction in flight
  logic              we_q;        // in-flight transaction is a store
  logic              if_gnt_q, d_gnt_q, if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              mem_en_q, mem_we_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              data_wins_s;
  logic [STV_W-1:0]  starve_d;

  // Winner selection and starvation-counter next value for an IDLE decision.
  always_comb begin
    data_wins_s = 1'b0;
    starve_d    = starve_q;
    if (bus.d_req && !(bus.if_req && (starve_q == STARVE_FULL))) begin
      data_wins_s = 1'b1;
    end else begin
      data_wins_s = 1'b0;
    end
    // Only a fetch that actually lost counts; anything else restarts the run.
    if (data_wins_s && bus.if_req) begin
      if (starve_q == STARVE_FULL) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + STARVE_ONE;
      end
    end else begin
      starve_d = {STV_W{1'b0}};
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      lat_q       <= {LAT_W{1'b0}};
      starve_q    <= {STV_W{1'b0}};
      sel_data_q  <= 1'b0;
      we_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          starve_q    <= starve_d;
          if (bus.if_req || bus.d_req) begin
            // Command and grant are loaded now so they appear during ISSUE.
            sel_data_q  <= data_wins_s;
            we_q        <= data_wins_s & bus.d_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= data_wins_s & bus.d_we;
            mem_addr_q  <= data_wins_s ? bus.d_addr : bus.if_addr;
            mem_wdata_q <= data_wins_s ? bus.d_wdata : {DATA_W{1'b0}};
            d_gnt_q     <= data_wins_s;
            if_gnt_q    <= ~data_wins_s;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if_gnt_q <= 1'b0;
          d_gnt_q  <= 1'b0;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          lat_q    <= LAT_LOAD;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          lat_q <= lat_q - LAT_ONE;
          // lat_q reaches 1 in the cycle mem_rdata is valid.
          if (lat_q == LAT_ONE) begin
            if (!we_q) begin
              if (sel_data_q) begin
                d_rdata_q <= bus.mem_rdata;
              end else begin
                if_rdata_q <= bus.mem_rdata;
              end
            end
            d_rvalid_q  <= sel_data_q;
            if_rvalid_q <= ~sel_data_q;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          if_gnt_q    <= 1'b0;
          d_gnt_q     <= 1'b0;
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule
